// File: rtl/enc_pkg.sv
// Shared types and helpers for the bit-serialising encoder.
package enc_pkg;

    typedef enum logic {
        ENC_IDLE,
        ENC_EMIT
    } enc_state_t;

    // Index width, clamped to one bit so an N=2 (or smaller) build still has a usable port.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/prio_enc_comb.sv
// Combinational priority encoder: reports whether any bit is set, the index of the
// winning bit (highest or lowest per MSB_FIRST) and that bit as a one-hot mask.
module prio_enc_comb
    import enc_pkg::*;
#(
    parameter int N = 8,
    parameter int MSB_FIRST = 1,
    localparam int W = idx_width(N)
) (
    input  logic [N-1:0] vec,
    output logic         any,
    output logic [W-1:0] idx,
    output logic [N-1:0] onehot
);

    // The loop direction is chosen so that the last set bit visited is the winner.
    always_comb begin
        any = 1'b0;
        idx = '0;
        if (MSB_FIRST != 0) begin
            for (int i = 0; i < N; i++) begin
                if (vec[i]) begin
                    any = 1'b1;
                    idx = W'(i);
                end
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (vec[i]) begin
                    any = 1'b1;
                    idx = W'(i);
                end
            end
        end
        onehot = any ? (N'(1) << idx) : '0;
    end

endmodule

// File: rtl/enc_bit_serialiser.sv
// Accepts an N-bit request vector and emits the index of each set bit, one per beat.
// Optional feature: define ENC_POPCOUNT_EN to add the out_cnt popcount port.
module enc_bit_serialiser
    import enc_pkg::*;
#(
    parameter int N = 8,
    parameter int MSB_FIRST = 1,
    localparam int W = idx_width(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] in_vec,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_idx,
    output logic         out_zero,
    output logic         out_last,
    output logic         out_valid,
    input  logic         out_ready
`ifdef ENC_POPCOUNT_EN
    ,
    output logic [W:0]   out_cnt
`endif
);

    enc_state_t   state;
    enc_state_t   state_next;
    logic [N-1:0] residual;
    logic [N-1:0] residual_next;
    logic [N-1:0] onehot;
    logic [W-1:0] pe_idx;
    logic         any;
    logic         emitting;
    logic         out_fire;
    logic         in_fire;

    prio_enc_comb #(
        .N         (N),
        .MSB_FIRST (MSB_FIRST)
    ) u_prio (
        .vec    (residual),
        .any    (any),
        .idx    (pe_idx),
        .onehot (onehot)
    );

    // Outputs come straight from the residual register, so they cannot move while stalled.
    assign emitting  = (state == ENC_EMIT);
    assign out_valid = emitting;
    assign out_idx   = emitting ? pe_idx : '0;
    assign out_zero  = emitting & ~any;
    assign out_last  = emitting & ((residual & ~onehot) == '0);
    assign out_fire  = out_valid & out_ready;
    assign in_ready  = (state == ENC_IDLE) | (out_fire & out_last);
    assign in_fire   = in_valid & in_ready;

    // A new vector accepted on the final beat overrides the return to idle.
    always_comb begin
        state_next    = state;
        residual_next = residual;
        if (out_fire) begin
            residual_next = residual & ~onehot;
            if (out_last) begin
                state_next = ENC_IDLE;
            end
        end
        if (in_fire) begin
            residual_next = in_vec;
            state_next    = ENC_EMIT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ENC_IDLE;
            residual <= '0;
        end else begin
            state    <= state_next;
            residual <= residual_next;
        end
    end

`ifdef ENC_POPCOUNT_EN
    logic [W:0] cnt_next;

    always_comb begin
        cnt_next = '0;
        for (int i = 0; i < N; i++) begin
            cnt_next = cnt_next + (W + 1)'(in_vec[i]);
        end
    end

    // The count belongs to the whole vector, so it only changes on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_cnt <= '0;
        end else if (in_fire) begin
            out_cnt <= cnt_next;
        end
    end
`endif

endmodule

// File: tb/tb_enc_bit_serialiser.sv
// Directed self-checking bench for enc_bit_serialiser across N=4, N=8 (both orders) and N=5.
module tb_enc_bit_serialiser;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // Shared stimulus for the two N=8 instances (a: MSB first, b: LSB first).
    logic [7:0] vec8;
    logic       valid8;
    logic       ready8;
    logic       a_in_ready, a_zero, a_last, a_valid;
    logic       b_in_ready, b_zero, b_last, b_valid;
    logic [2:0] a_idx, b_idx;

    logic [3:0] vec4;
    logic       valid4, oready4;
    logic       c_in_ready, c_zero, c_last, c_valid;
    logic [1:0] c_idx;

    logic [4:0] vec5;
    logic       valid5, oready5;
    logic       d_in_ready, d_zero, d_last, d_valid;
    logic [2:0] d_idx;

`ifdef ENC_POPCOUNT_EN
    logic [3:0] a_cnt, b_cnt, d_cnt;
    logic [2:0] c_cnt;
`endif

    int passed = 0;
    int failed = 0;
    int total  = 0;

    int ea[4] = '{7, 5, 2, 0};
    int eb[4] = '{0, 2, 5, 7};

    enc_bit_serialiser #(.N(8), .MSB_FIRST(1)) dut_a (
        .clk(clk), .rst(rst), .in_vec(vec8), .in_valid(valid8), .in_ready(a_in_ready),
        .out_idx(a_idx), .out_zero(a_zero), .out_last(a_last), .out_valid(a_valid),
        .out_ready(ready8)
`ifdef ENC_POPCOUNT_EN
        , .out_cnt(a_cnt)
`endif
    );

    enc_bit_serialiser #(.N(8), .MSB_FIRST(0)) dut_b (
        .clk(clk), .rst(rst), .in_vec(vec8), .in_valid(valid8), .in_ready(b_in_ready),
        .out_idx(b_idx), .out_zero(b_zero), .out_last(b_last), .out_valid(b_valid),
        .out_ready(ready8)
`ifdef ENC_POPCOUNT_EN
        , .out_cnt(b_cnt)
`endif
    );

    enc_bit_serialiser #(.N(4), .MSB_FIRST(1)) dut_c (
        .clk(clk), .rst(rst), .in_vec(vec4), .in_valid(valid4), .in_ready(c_in_ready),
        .out_idx(c_idx), .out_zero(c_zero), .out_last(c_last), .out_valid(c_valid),
        .out_ready(oready4)
`ifdef ENC_POPCOUNT_EN
        , .out_cnt(c_cnt)
`endif
    );

    enc_bit_serialiser #(.N(5), .MSB_FIRST(1)) dut_d (
        .clk(clk), .rst(rst), .in_vec(vec5), .in_valid(valid5), .in_ready(d_in_ready),
        .out_idx(d_idx), .out_zero(d_zero), .out_last(d_last), .out_valid(d_valid),
        .out_ready(oready5)
`ifdef ENC_POPCOUNT_EN
        , .out_cnt(d_cnt)
`endif
    );

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        total++;
        assert (observed === expected) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [7:0] v, input logic vld, input logic rdy);
        vec8   = v;
        valid8 = vld;
        ready8 = rdy;
    endtask

    // Inputs are driven and outputs sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_pair(input string tag, input int exp_a, input int exp_b,
                              input logic exp_last, input int exp_cnt);
        check_output({tag, " a_valid"}, 32'(a_valid), 1);
        check_output({tag, " b_valid"}, 32'(b_valid), 1);
        check_output({tag, " a_idx"}, 32'(a_idx), exp_a);
        check_output({tag, " b_idx"}, 32'(b_idx), exp_b);
        check_output({tag, " a_last"}, 32'(a_last), 32'(exp_last));
        check_output({tag, " b_last"}, 32'(b_last), 32'(exp_last));
`ifdef ENC_POPCOUNT_EN
        check_output({tag, " a_cnt"}, 32'(a_cnt), exp_cnt);
        check_output({tag, " b_cnt"}, 32'(b_cnt), exp_cnt);
`else
        if (exp_cnt < 0) $display("[TB] unexpected negative count");
`endif
    endtask

    initial begin
        rst = 1'b1;
        apply_stimulus(8'h00, 1'b0, 1'b0);
        vec4 = '0; valid4 = 1'b0; oready4 = 1'b0;
        vec5 = '0; valid5 = 1'b0; oready5 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] reset state");
        check_output("rst a_valid", 32'(a_valid), 0);
        check_output("rst a_idx", 32'(a_idx), 0);
        check_output("rst a_zero", 32'(a_zero), 0);
        check_output("rst a_last", 32'(a_last), 0);
        check_output("rst a_in_ready", 32'(a_in_ready), 1);
        check_output("rst d_valid", 32'(d_valid), 0);
`ifdef ENC_POPCOUNT_EN
        check_output("rst a_cnt", 32'(a_cnt), 0);
`endif

        $display("[TB] N=4 single bit");
        vec4 = 4'b0100; valid4 = 1'b1; oready4 = 1'b1;
        check_output("n4 pre valid", 32'(c_valid), 0);
        tick();
        valid4 = 1'b0;
        check_output("n4 valid", 32'(c_valid), 1);
        check_output("n4 idx", 32'(c_idx), 2);
        check_output("n4 last", 32'(c_last), 1);
        check_output("n4 zero", 32'(c_zero), 0);
`ifdef ENC_POPCOUNT_EN
        check_output("n4 cnt", 32'(c_cnt), 1);
`endif
        tick();
        check_output("n4 done valid", 32'(c_valid), 0);
        check_output("n4 done in_ready", 32'(c_in_ready), 1);

        $display("[TB] 8'hA5 both orders with stalls");
        apply_stimulus(8'hA5, 1'b1, 1'b0);
        tick();
        apply_stimulus(8'h00, 1'b0, 1'b0);
        check_output("a5 in_ready busy", 32'(a_in_ready), 0);
        check_output("a5 zero", 32'(a_zero), 0);
        check_pair("a5 stall0", 7, 0, 1'b0, 4);
        tick();
        check_pair("a5 stall0 held", 7, 0, 1'b0, 4);
        ready8 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check_pair("a5 beat", ea[k], eb[k], (k == 3), 4);
            if (k == 2) begin
                ready8 = 1'b0;
                tick();
                check_pair("a5 stall2 held", ea[k], eb[k], 1'b0, 4);
                ready8 = 1'b1;
            end
            tick();
        end
        check_output("a5 done a_valid", 32'(a_valid), 0);
        check_output("a5 done b_valid", 32'(b_valid), 0);
        check_output("a5 done in_ready", 32'(a_in_ready), 1);

        $display("[TB] zero vector then full vector");
        apply_stimulus(8'h00, 1'b1, 1'b1);
        tick();
        apply_stimulus(8'h00, 1'b0, 1'b1);
        check_output("zero a_zero", 32'(a_zero), 1);
        check_output("zero b_zero", 32'(b_zero), 1);
        check_pair("zero beat", 0, 0, 1'b1, 0);
        tick();
        check_output("zero done valid", 32'(a_valid), 0);
        apply_stimulus(8'hFF, 1'b1, 1'b1);
        tick();
        apply_stimulus(8'h00, 1'b0, 1'b1);
        check_output("ff a_zero", 32'(a_zero), 0);
        for (int k = 0; k < 8; k++) begin
            check_pair("ff beat", 7 - k, k, (k == 7), 8);
            tick();
        end
        check_output("ff done valid", 32'(a_valid), 0);

        $display("[TB] back-to-back vectors");
        apply_stimulus(8'h03, 1'b1, 1'b1);
        tick();
        apply_stimulus(8'h80, 1'b1, 1'b1);
        check_pair("b2b beat0", 1, 0, 1'b0, 2);
        check_output("b2b busy in_ready", 32'(a_in_ready), 0);
        tick();
        check_pair("b2b beat1", 0, 1, 1'b1, 2);
        check_output("b2b last in_ready", 32'(a_in_ready), 1);
        tick();
        apply_stimulus(8'h00, 1'b0, 1'b1);
        check_pair("b2b beat2", 7, 7, 1'b1, 1);
        tick();
        check_output("b2b done valid", 32'(a_valid), 0);

        $display("[TB] N=5 reset mid-vector and full vector");
        vec5 = 5'b10001; valid5 = 1'b1; oready5 = 1'b1;
        tick();
        valid5 = 1'b0;
        check_output("n5 beat0 valid", 32'(d_valid), 1);
        check_output("n5 beat0 idx", 32'(d_idx), 4);
        check_output("n5 beat0 last", 32'(d_last), 0);
`ifdef ENC_POPCOUNT_EN
        check_output("n5 beat0 cnt", 32'(d_cnt), 2);
`endif
        tick();
        check_output("n5 beat1 idx", 32'(d_idx), 0);
        check_output("n5 beat1 last", 32'(d_last), 1);
        rst = 1'b1;
        tick();
        check_output("n5 rst valid", 32'(d_valid), 0);
        check_output("n5 rst idx", 32'(d_idx), 0);
        check_output("n5 rst last", 32'(d_last), 0);
        check_output("n5 rst zero", 32'(d_zero), 0);
        check_output("n5 rst in_ready", 32'(d_in_ready), 1);
`ifdef ENC_POPCOUNT_EN
        check_output("n5 rst cnt", 32'(d_cnt), 0);
`endif
        rst = 1'b0;
        tick();
        check_output("n5 post rst valid", 32'(d_valid), 0);
        vec5 = 5'b11111; valid5 = 1'b1;
        tick();
        valid5 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check_output("n5 full valid", 32'(d_valid), 1);
            check_output("n5 full idx", 32'(d_idx), 4 - k);
            check_output("n5 full last", 32'(d_last), (k == 4) ? 1 : 0);
`ifdef ENC_POPCOUNT_EN
            check_output("n5 full cnt", 32'(d_cnt), 5);
`endif
            tick();
        end
        check_output("n5 full done valid", 32'(d_valid), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
